sha256_msg_schedule: RTL

Message-schedule expander for the SHA-256 datapath. It accepts one 512-bit padded block from the message splitter and streams the schedule words W0..W(NUM_ROUNDS-1), one per accepted beat, to the compression round engine. A 16-word sliding window computes each new word with the sigma0/sigma1 mixing functions, so each word needs only one adder tree.

---
 rtl/sha256_pkg.sv | 53 +++++
 rtl/msg_sched_sigma.sv | 30 +++
 rtl/sha256_msg_schedule.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// ============================================================================
//  Module   : sha256_pkg
//  Purpose  : Shared SHA-256 definitions: 32-bit word type, the 64-entry
//             round-constant table, and the rotate/shift amounts used by the
//             message-schedule mixing functions sigma0/sigma1.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sha256_pkg;

  typedef logic [31:0] word_t;

  // sigma0(x) = ROTR7 ^ ROTR18 ^ SHR3
  localparam int unsigned SIG0_ROT_A = 7;
  localparam int unsigned SIG0_ROT_B = 18;
  localparam int unsigned SIG0_SHR   = 3;
  // sigma1(x) = ROTR17 ^ ROTR19 ^ SHR10
  localparam int unsigned SIG1_ROT_A = 17;
  localparam int unsigned SIG1_ROT_B = 19;
  localparam int unsigned SIG1_SHR   = 10;

  localparam logic SIG_SEL_0 = 1'b0;
  localparam logic SIG_SEL_1 = 1'b1;

  localparam word_t SHA256_K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Rotate right by a constant amount (n in 1..31).
  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage

`default_nettype wire

// File: rtl/msg_sched_sigma.sv
// ============================================================================
//  Module   : msg_sched_sigma
//  Purpose  : Combinational SHA-256 message-schedule mixing function.
//             Selects sigma0 (i_sel=0) or sigma1 (i_sel=1).
//  Ports    : i_x   [31:0] input word
//             i_sel        0 = sigma0, 1 = sigma1
//             o_y   [31:0] mixed word
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module msg_sched_sigma
  import sha256_pkg::*;
(
  input  logic [31:0] i_x,
  input  logic        i_sel,
  output logic [31:0] o_y
);

  word_t w_sig0;
  word_t w_sig1;

  assign w_sig0 = rotr(i_x, SIG0_ROT_A) ^ rotr(i_x, SIG0_ROT_B) ^ (i_x >> SIG0_SHR);
  assign w_sig1 = rotr(i_x, SIG1_ROT_A) ^ rotr(i_x, SIG1_ROT_B) ^ (i_x >> SIG1_SHR);

  assign o_y = (i_sel == SIG_SEL_1) ? w_sig1 : w_sig0;

endmodule

`default_nettype wire

// File: rtl/sha256_msg_schedule.sv
// ============================================================================
//  Module   : sha256_msg_schedule
//  Purpose  : SHA-256 message-schedule expander. Accepts one 512-bit padded
//             block and streams W0..W(NUM_ROUNDS-1), one word per handshake,
//             using a 16-word sliding window.
//  Config   : `define SHA256_SCHED_KADD_EN -> w_data = W_t + K_t (mod 2^32)
//             otherwise                     -> w_data = W_t
//  Ports    : clk, rst (sync, active-low)
//             blk_valid/blk_ready/blk_data[511:0]  block input
//             w_valid/w_ready/w_data[31:0]         schedule word output
//             w_idx[5:0]  round index, w_last  high on t == NUM_ROUNDS-1
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sha256_msg_schedule
  import sha256_pkg::*;
#(
  parameter int NUM_ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_data,
  output logic [5:0]   w_idx,
  output logic         w_last
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_RUN    = 1'b1;
  localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

  logic [0:0] r_state;
  word_t      r_win [16];
  logic [5:0] r_t;

  word_t w_sig0;
  word_t w_sig1;
  word_t w_next;
  word_t w_word;
  logic  w_run;
  logic  w_is_last;

  msg_sched_sigma u_sigma0 (
    .i_x   (r_win[1]),
    .i_sel (SIG_SEL_0),
    .o_y   (w_sig0)
  );

  msg_sched_sigma u_sigma1 (
    .i_x   (r_win[14]),
    .i_sel (SIG_SEL_1),
    .o_y   (w_sig1)
  );

  // W(t+16) from the current window: offsets 14, 9, 1, 0 correspond to
  // W(t+14), W(t+9), W(t+1), W(t).
  assign w_next = w_sig1 + r_win[9] + w_sig0 + r_win[0];

  assign w_run     = (r_state == S_RUN);
  assign w_is_last = (r_t == LAST_IDX);

`ifdef SHA256_SCHED_KADD_EN
  assign w_word = r_win[0] + SHA256_K[r_t];
`else
  assign w_word = r_win[0];
`endif

  // Outputs are forced to zero outside RUN so the post-reset values are
  // clean in both builds.
  assign blk_ready = !w_run;
  assign w_valid   = w_run;
  assign w_data    = w_run ? w_word : '0;
  assign w_idx     = r_t;
  assign w_last    = w_run && w_is_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_t     <= '0;
      for (int i = 0; i < 16; i++) begin
        r_win[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (blk_valid) begin
            for (int i = 0; i < 16; i++) begin
              r_win[i] <= blk_data[511 - 32*i -: 32];
            end
            r_t     <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (w_ready) begin
            for (int i = 0; i < 15; i++) begin
              r_win[i] <= r_win[i+1];
            end
            r_win[15] <= w_next;
            if (w_is_last) begin
              r_t     <= '0;
              r_state <= S_IDLE;
            end else begin
              r_t <= r_t + 6'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
